// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and round-robin pick helper for the data-memory arbiter
package dmem_arb_pkg;

    localparam int MAX_NREQ = 8;

    typedef logic [2:0] st_id_t;

    typedef struct packed {
        logic   found;
        st_id_t id;
    } rr_pick_t;

    // First set bit of valid_vec at or above ptr, wrapping modulo nreq.
    // Iterating downward lets the lowest distance from ptr win the last write.
    function automatic rr_pick_t rr_pick(input logic [MAX_NREQ-1:0] valid_vec,
                                         input st_id_t ptr,
                                         input int nreq);
        rr_pick_t res;
        int       idx;
        res.found = 1'b0;
        res.id    = '0;
        for (int i = MAX_NREQ - 1; i >= 0; i--) begin
            idx = int'(ptr) + i;
            if (idx >= nreq) begin
                idx = idx - nreq;
            end
            if ((i < nreq) && valid_vec[idx[2:0]]) begin
                res.found = 1'b1;
                res.id    = st_id_t'(idx);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dmem_arb_idfifo.sv
// rtl/dmem_arb_idfifo.sv - in-order requester ID FIFO for routing tagless store completions
module dmem_arb_idfifo #(
    parameter int W     = 1,
    parameter int DEPTH = 4,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  pop_data,
    output logic          full,
    output logic          empty,
    output logic [PW:0]   count
);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Storage is left unreset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/dmem_arb.sv
// rtl/dmem_arb.sv - round-robin arbiter sharing one data-memory load/store port among NREQ requesters
module dmem_arb
    import dmem_arb_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int RTAG_W   = 3,
    parameter int ST_OUTST = 4,
    localparam int ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int MTAG_W  = RTAG_W + ID_W,
    localparam int CNT_W   = ((ST_OUTST > 1) ? $clog2(ST_OUTST) : 1) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      rq_ld_valid,
    output logic [NREQ-1:0]      rq_ld_ready,
    input  logic [NREQ*32-1:0]   rq_ld_addr,
    input  logic [NREQ*RTAG_W-1:0] rq_ld_tag,
    output logic [NREQ-1:0]      rq_ld_resp_valid,
    input  logic [NREQ-1:0]      rq_ld_resp_ready,
    output logic [63:0]          rq_ld_resp_data,
    output logic [RTAG_W-1:0]    rq_ld_resp_tag,
    output logic                 rq_ld_resp_err,
    input  logic [NREQ-1:0]      rq_st_valid,
    output logic [NREQ-1:0]      rq_st_ready,
    input  logic [NREQ*32-1:0]   rq_st_addr,
    input  logic [NREQ*64-1:0]   rq_st_wdata,
    input  logic [NREQ*8-1:0]    rq_st_wstrb,
    output logic [NREQ-1:0]      rq_st_resp_valid,
    input  logic [NREQ-1:0]      rq_st_resp_ready,
    output logic                 m_ld_valid,
    input  logic                 m_ld_ready,
    output logic [31:0]          m_ld_addr,
    output logic [MTAG_W-1:0]    m_ld_tag,
    input  logic                 m_ld_resp_valid,
    output logic                 m_ld_resp_ready,
    input  logic [63:0]          m_ld_resp_data,
    input  logic [MTAG_W-1:0]    m_ld_resp_tag,
    input  logic                 m_ld_resp_err,
    output logic                 m_st_valid,
    input  logic                 m_st_ready,
    output logic [31:0]          m_st_addr,
    output logic [63:0]          m_st_wdata,
    output logic [7:0]           m_st_wstrb,
    input  logic                 m_st_resp_valid,
    output logic                 m_st_resp_ready
);

    // Load arbitration state
    logic [ID_W-1:0]   ld_rr;
    logic              ld_lock;
    logic [ID_W-1:0]   ld_gid_q;
    rr_pick_t          ld_pick;
    logic [ID_W-1:0]   ld_gid;
    logic [ID_W-1:0]   ld_gid_nxt;
    logic              ld_have;
    logic              ld_sel_valid;
    logic [RTAG_W-1:0] ld_sel_tag;
    logic [ID_W-1:0]   ld_resp_id;

    // Store arbitration state
    logic [ID_W-1:0]   st_rr;
    logic              st_lock;
    logic [ID_W-1:0]   st_gid_q;
    rr_pick_t          st_pick;
    logic [ID_W-1:0]   st_gid;
    logic [ID_W-1:0]   st_gid_nxt;
    logic              st_have;
    logic              st_sel_valid;
    logic              st_room;

    // ID FIFO interface
    logic              st_push;
    logic              st_pop;
    logic [ID_W-1:0]   st_head;
    logic              st_full;
    logic              st_empty;
    logic [CNT_W-1:0]  st_count;

    always_comb begin
        ld_pick      = rr_pick(MAX_NREQ'(rq_ld_valid), st_id_t'(ld_rr), NREQ);
        ld_gid       = ld_lock ? ld_gid_q : ID_W'(ld_pick.id);
        ld_have      = ld_lock || ld_pick.found;
        ld_gid_nxt   = (ld_gid == ID_W'(NREQ - 1)) ? '0 : ld_gid + 1'b1;
        ld_sel_valid = 1'b0;
        ld_sel_tag   = '0;
        m_ld_addr    = '0;
        rq_ld_ready  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (ld_gid == ID_W'(i)) begin
                ld_sel_valid   = rq_ld_valid[i];
                ld_sel_tag     = rq_ld_tag[i*RTAG_W +: RTAG_W];
                m_ld_addr      = rq_ld_addr[i*32 +: 32];
                rq_ld_ready[i] = ld_have && m_ld_ready && !rst;
            end
        end
        m_ld_valid = ld_have && ld_sel_valid && !rst;
        m_ld_tag   = {ld_gid, ld_sel_tag};
    end

    // A stalled grant is frozen until its handshake so the address cannot change under the memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_rr    <= '0;
            ld_lock  <= 1'b0;
            ld_gid_q <= '0;
        end else if (m_ld_valid) begin
            if (m_ld_ready) begin
                ld_lock <= 1'b0;
                ld_rr   <= ld_gid_nxt;
            end else begin
                ld_lock  <= 1'b1;
                ld_gid_q <= ld_gid;
            end
        end
    end

    // Load responses steer by the ID field in the upper tag bits; unknown IDs are sunk.
    always_comb begin
        ld_resp_id       = m_ld_resp_tag[MTAG_W-1:RTAG_W];
        rq_ld_resp_valid = '0;
        m_ld_resp_ready  = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (ld_resp_id == ID_W'(i)) begin
                rq_ld_resp_valid[i] = m_ld_resp_valid;
                m_ld_resp_ready     = rq_ld_resp_ready[i];
            end
        end
        if (rst) begin
            rq_ld_resp_valid = '0;
            m_ld_resp_ready  = 1'b0;
        end
        rq_ld_resp_data = m_ld_resp_data;
        rq_ld_resp_tag  = m_ld_resp_tag[RTAG_W-1:0];
        rq_ld_resp_err  = m_ld_resp_err;
    end

    always_comb begin
        st_room      = !st_full && (32'(st_count) < ST_OUTST);
        st_pick      = rr_pick(MAX_NREQ'(rq_st_valid), st_id_t'(st_rr), NREQ);
        st_gid       = st_lock ? st_gid_q : ID_W'(st_pick.id);
        st_have      = st_lock || st_pick.found;
        st_gid_nxt   = (st_gid == ID_W'(NREQ - 1)) ? '0 : st_gid + 1'b1;
        st_sel_valid = 1'b0;
        m_st_addr    = '0;
        m_st_wdata   = '0;
        m_st_wstrb   = '0;
        rq_st_ready  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (st_gid == ID_W'(i)) begin
                st_sel_valid   = rq_st_valid[i];
                m_st_addr      = rq_st_addr[i*32 +: 32];
                m_st_wdata     = rq_st_wdata[i*64 +: 64];
                m_st_wstrb     = rq_st_wstrb[i*8 +: 8];
                rq_st_ready[i] = st_have && st_room && m_st_ready && !rst;
            end
        end
        m_st_valid = st_have && st_sel_valid && st_room && !rst;
        st_push    = m_st_valid && m_st_ready;
    end

    // With the FIFO full m_st_valid is low, so no lock is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_rr    <= '0;
            st_lock  <= 1'b0;
            st_gid_q <= '0;
        end else if (m_st_valid) begin
            if (m_st_ready) begin
                st_lock <= 1'b0;
                st_rr   <= st_gid_nxt;
            end else begin
                st_lock  <= 1'b1;
                st_gid_q <= st_gid;
            end
        end
    end

    // Completions arrive in issue order, so the FIFO head names their owner.
    always_comb begin
        rq_st_resp_valid = '0;
        m_st_resp_ready  = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (!st_empty && (st_head == ID_W'(i))) begin
                rq_st_resp_valid[i] = m_st_resp_valid;
                m_st_resp_ready     = rq_st_resp_ready[i];
            end
        end
        if (rst) begin
            rq_st_resp_valid = '0;
            m_st_resp_ready  = 1'b0;
        end
        st_pop = m_st_resp_valid && m_st_resp_ready && !st_empty;
    end

    dmem_arb_idfifo #(
        .W     (ID_W),
        .DEPTH (ST_OUTST)
    ) u_idfifo (
        .clk       (clk),
        .rst       (rst),
        .push      (st_push),
        .push_data (st_gid),
        .pop       (st_pop),
        .pop_data  (st_head),
        .full      (st_full),
        .empty     (st_empty),
        .count     (st_count)
    );

endmodule
